dsm_bitstream_modulator: RTL and testbench

- Second-order, 1-bit delta-sigma modulator.
- Converts a stream of signed PCM samples into a single-bit oversampled stream.
- This is the encoding end of the delta-sigma link: it generates the bitstream that our CIC decimation path consumes on ui_in[0], for on-chip loopback and for driving an external reconstruction filter.
- Each accepted sample is held for OSR clocks and noise-shaped with NTF = (1 - z^-1)^2.

---
 rtl/dsm_pkg.sv | 33 +++
 rtl/dsm_bitstream_modulator_loop2.sv | 57 +++++
 rtl/dsm_bitstream_modulator.sv | 149 ++++++++++++++
 tb/tb_dsm_bitstream_modulator.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared definitions for the second-order delta-sigma bitstream modulator:
// default sizes, accumulator width derivation, FSM states and saturation.
package dsm_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int OSR_DEF      = 64;
  localparam int ACC_HEADROOM = 4;
  localparam int SAT_W        = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsm_state_e;

  function automatic int acc_w_of(input int data_w);
    return data_w + ACC_HEADROOM;
  endfunction

  // Clamp a wide signed sum to the symmetric range of an acc_w-bit accumulator.
  function automatic logic signed [SAT_W-1:0] sat_acc(input logic signed [SAT_W-1:0] x,
                                                      input int acc_w);
    logic signed [SAT_W-1:0] lim;
    lim = $signed((32'd1 << (acc_w - 1)) - 32'd1);
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/dsm_bitstream_modulator_loop2.sv
// Error-feedback core with NTF = (1 - z^-1)^2: one iteration per enabled clock,
// registered 1-bit decision y (1 = +FS, 0 = -FS).
module dsm_loop2
  import dsm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_w_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] u,
  output logic              y
);

  localparam logic signed [SAT_W-1:0] FS = SAT_W'(1) <<< (DATA_W - 1);

  logic signed [ACC_W-1:0] e1_q, e1_d, e2_q, e2_d;
  logic                    y_q, y_d;
  logic signed [SAT_W-1:0] u_ext, w, v;
  logic signed [ACC_W-1:0] e_acc;

  always_comb begin
    u_ext = SAT_W'($signed(u));
    w     = sat_acc(u_ext + (SAT_W'(e1_q) <<< 1) - SAT_W'(e2_q), ACC_W);
    v     = w[SAT_W-1] ? -FS : FS;
    e_acc = ACC_W'(sat_acc(w - v, ACC_W));
    e1_d  = e1_q;
    e2_d  = e2_q;
    y_d   = y_q;
    if (clr) begin
      e1_d = '0;
      e2_d = '0;
      y_d  = 1'b0;
    end else if (en) begin
      y_d  = ~w[SAT_W-1];
      e2_d = e1_q;
      e1_d = e_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_q <= '0;
      e2_q <= '0;
      y_q  <= 1'b0;
    end else begin
      e1_q <= e1_d;
      e2_q <= e2_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/dsm_bitstream_modulator.sv
// Second-order 1-bit delta-sigma modulator: two-stage sample buffer, per-sample
// OSR-clock frame counter, IDLE/RUN control, and the dsm_loop2 core.
module dsm_bitstream_modulator
  import dsm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OSR    = OSR_DEF,
  parameter int ACC_W  = acc_w_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stop,
  input  logic              clear_flags,
  output logic              dsm_out,
  output logic              sample_tick,
  output logic              busy,
  output logic              underrun
);

  localparam int              PH_W    = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  dsm_state_e        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] nxt_q, nxt_d;
  logic              nxt_valid_q, nxt_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              stop_pend_q, stop_pend_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic accept, stop_req, under_set, loop_en, loop_clr;

  // Handshake: a sample transfers when in_valid & in_ready at a clk edge;
  // in_ready is the registered complement of nxt_valid, so it never depends
  // on in_valid in the same cycle.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    stop_pend_d = stop_pend_q;
    tick_d      = 1'b0;
    under_set   = 1'b0;
    loop_en     = 1'b0;
    loop_clr    = 1'b0;
    stop_req    = stop | stop_pend_q;
    accept      = in_valid & in_ready_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (nxt_valid_q) begin
          cur_d       = nxt_q;
          nxt_valid_d = 1'b0;
          tick_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        loop_en = 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (stop_req) begin
            state_d     = IDLE;
            cur_d       = '0;
            nxt_valid_d = 1'b0;
            stop_pend_d = 1'b0;
            loop_clr    = 1'b1;
          end else begin
            tick_d = 1'b1;
            if (nxt_valid_q) begin
              cur_d       = nxt_q;
              nxt_valid_d = 1'b0;
            end else begin
              under_set = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stop boundary drops anything pending, including a same-cycle accept.
    if (accept && !loop_clr) begin
      nxt_d       = in_data;
      nxt_valid_d = 1'b1;
    end

    underrun_d = under_set ? 1'b1 : (clear_flags ? 1'b0 : underrun_q);
    in_ready_d = ~nxt_valid_d;
    busy_d     = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stop_pend_q <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      in_ready_q  <= in_ready_d;
      stop_pend_q <= stop_pend_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  dsm_loop2 #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_loop (
    .clk(clk),
    .rst(rst),
    .en (loop_en),
    .clr(loop_clr),
    .u  (cur_q),
    .y  (dsm_out)
  );

  assign in_ready    = in_ready_q;
  assign sample_tick = tick_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dsm_bitstream_modulator.sv
// Self-checking bench for dsm_bitstream_modulator: a transaction-level model of
// the sample buffer, frame boundaries and error-feedback arithmetic.
module tb_dsm_bitstream_modulator;

  localparam int     DATA_W = 16;
  localparam int     OSR    = 64;
  localparam longint FS     = 64'sd32768;
  localparam longint LIM    = 64'sd524287;

  logic clk = 1'b0;
  logic rst, in_valid, stop, clear_flags;
  logic [DATA_W-1:0] in_data;
  logic in_ready, dsm_out, sample_tick, busy, underrun;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic       bit_log[$];
  logic [0:0] exp_q[$];
  logic [4:0] obs;

  // reference model state
  bit     m_run, m_nxt_v, m_stop_pend, m_y, m_tick, m_under;
  int     m_phase, m_cur, m_nxt;
  longint m_e1, m_e2;

  always #5 clk = ~clk;

  dsm_bitstream_modulator #(
    .DATA_W(DATA_W),
    .OSR   (OSR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stop       (stop),
    .clear_flags(clear_flags),
    .dsm_out    (dsm_out),
    .sample_tick(sample_tick),
    .busy       (busy),
    .underrun   (underrun)
  );

  assign obs = {dsm_out, in_ready, sample_tick, busy, underrun};

  function automatic longint clamp(input longint x);
    if (x > LIM) return LIM;
    if (x < -LIM) return -LIM;
    return x;
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_y, ~m_nxt_v, m_tick, m_run, m_under};
  endfunction

  function automatic int ones_in_frame(input int k);
    int n = 0;
    for (int i = 0; i < OSR; i++) n += int'(bit_log[k*OSR + i]);
    return n;
  endfunction

  task automatic model_update();
    bit acc, stopping, set_u;
    longint w, e;
    if (rst) begin
      m_run = 0; m_phase = 0; m_cur = 0; m_nxt_v = 0; m_stop_pend = 0;
      m_e1 = 0; m_e2 = 0; m_y = 0; m_tick = 0; m_under = 0;
      return;
    end
    acc = in_valid && !m_nxt_v;
    stopping = 0; set_u = 0; m_tick = 0;
    if (!m_run) begin
      if (m_nxt_v) begin
        m_cur = m_nxt; m_nxt_v = 0; m_run = 1; m_phase = 0; m_tick = 1;
      end
    end else begin
      w = clamp(m_cur + 2*m_e1 - m_e2);
      m_y = (w >= 0);
      e = clamp(w - (m_y ? FS : -FS));
      m_e2 = m_e1;
      m_e1 = e;
      if (m_phase == OSR-1) begin
        m_phase = 0;
        if (stop || m_stop_pend) begin
          m_run = 0; m_cur = 0; m_e1 = 0; m_e2 = 0; m_nxt_v = 0;
          m_y = 0; m_stop_pend = 0; stopping = 1;
        end else begin
          m_tick = 1;
          if (m_nxt_v) begin m_cur = m_nxt; m_nxt_v = 0; end
          else set_u = 1;
        end
      end else begin
        m_phase++;
        if (stop) m_stop_pend = 1;
      end
    end
    if (acc && !stopping) begin
      m_nxt = int'($signed(in_data));
      m_nxt_v = 1;
    end
    if (set_u) m_under = 1;
    else if (clear_flags) m_under = 0;
  endtask

  task automatic step();
    bit pr;
    pr = m_run;
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    if (pr) bit_log.push_back(dsm_out);
  endtask

  task automatic reset_dut();
    rst = 1; in_valid = 0; stop = 0; clear_flags = 0; in_data = '0;
    step(); step();
    rst = 0;
    bit_log.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    int ticks = 0;
    rst = 1; in_valid = 0; stop = 0; clear_flags = 0; in_data = '0;
    repeat (3) begin
      step();
      n_checks++;
      if (obs !== 5'b01000) begin
        n_fails++; $display("FAIL reset_hold obs=%b exp=01000", obs);
      end
    end
    rst = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n_checks++;
      if (obs !== 5'b01000) begin
        n_fails++; $display("FAIL idle_outputs cyc=%0d obs=%b exp=01000", cyc, obs);
      end
      if (sample_tick) ticks++;
    end
    n_checks++;
    if (ticks !== 0) begin n_fails++; $display("FAIL idle_ticks got=%0d exp=0", ticks); end
  endtask

  task automatic test_zero();
    int last_tick = -1;
    reset_dut();
    in_data = '0; in_valid = 1;
    for (int i = 0; i < 4*OSR + 6; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL zero_cycle cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
      end
      if (sample_tick) begin
        if (last_tick >= 0) begin
          n_checks++;
          if (cyc - last_tick !== OSR) begin
            n_fails++; $display("FAIL zero_tick_period got=%0d exp=%0d", cyc - last_tick, OSR);
          end
        end
        last_tick = cyc;
      end
    end
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (bit_log.size() < 4*OSR) begin
      n_fails++; $display("FAIL zero_len got=%0d exp>=%0d", bit_log.size(), 4*OSR);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (bit_log[i] !== exp_q[i]) begin
          n_fails++; $display("FAIL zero_pattern idx=%0d got=%b exp=%b", i, bit_log[i], exp_q[i]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ones_in_frame(k) !== 32) begin
          n_fails++; $display("FAIL zero_ones frame=%0d got=%0d exp=32", k, ones_in_frame(k));
        end
      end
    end
    n_checks++;
    if (underrun !== 1'b0) begin n_fails++; $display("FAIL zero_underrun got=%b exp=0", underrun); end
    in_valid = 0;
  endtask

  task automatic test_dc(input int val, input int lo, input int hi);
    reset_dut();
    in_data = 16'(val); in_valid = 1;
    for (int i = 0; i < 50*OSR + 4; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL dc_cycle val=%0d cyc=%0d obs=%b exp=%b", val, cyc, obs, exp_vec());
      end
    end
    n_checks++;
    if (bit_log.size() < 50*OSR) begin
      n_fails++; $display("FAIL dc_len got=%0d exp>=%0d", bit_log.size(), 50*OSR);
    end else begin
      for (int k = 2; k < 50; k++) begin
        n_checks++;
        if (ones_in_frame(k) < lo || ones_in_frame(k) > hi) begin
          n_fails++;
          $display("FAIL dc_ones val=%0d frame=%0d got=%0d exp=%0d..%0d", val, k, ones_in_frame(k), lo, hi);
        end
      end
    end
    n_checks++;
    if (underrun !== 1'b0) begin n_fails++; $display("FAIL dc_underrun got=%b exp=0", underrun); end
    in_valid = 0;
  endtask

  task automatic test_back_to_back();
    int data, acc_cnt, n_tick, n_acc;
    bit acc;
    reset_dut();
    data = -20000 + int'($urandom_range(0, 1000));
    in_data = 16'(data); in_valid = 1;
    acc_cnt = 0; n_tick = 0; n_acc = 0;
    for (int i = 0; i < 8*OSR + 4; i++) begin
      acc = in_valid && in_ready;
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL b2b_cycle cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
      end
      if (acc) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_ready_drop got=%b exp=0", in_ready); end
        acc_cnt++; n_acc++;
        data += int'($urandom_range(2000, 4500));
        in_data = 16'(data);
      end
      if (sample_tick) begin
        if (n_tick > 0) begin
          n_checks++;
          if (acc_cnt !== 1) begin n_fails++; $display("FAIL b2b_accepts got=%0d exp=1", acc_cnt); end
        end
        acc_cnt = 0;
        n_tick++;
      end
    end
    n_checks++;
    if (n_tick < 8) begin n_fails++; $display("FAIL b2b_ticks got=%0d exp>=8", n_tick); end
    in_valid = 0;
  endtask

  task automatic test_underrun();
    int n_tick = 0;
    bit clr_prev;
    reset_dut();
    in_data = '0; in_valid = 1;
    step();
    in_valid = 0;
    for (int i = 0; i < 3*OSR + 8; i++) begin
      clear_flags = (n_tick == 2 && m_phase == 20);
      clr_prev = clear_flags;
      step();
      clear_flags = 0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL ur_cycle cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
      end
      if (clr_prev) begin
        n_checks++;
        if (underrun !== 1'b0) begin n_fails++; $display("FAIL ur_clear got=%b exp=0", underrun); end
      end
      if (sample_tick) begin
        n_tick++;
        n_checks++;
        if (underrun !== (n_tick >= 2)) begin
          n_fails++; $display("FAIL ur_flag tick=%0d got=%b exp=%b", n_tick, underrun, n_tick >= 2);
        end
      end
    end
    n_checks++;
    if (n_tick < 3) begin
      n_fails++; $display("FAIL ur_ticks got=%0d exp>=3", n_tick);
    end else if (bit_log.size() >= 2*OSR) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ones_in_frame(k) !== 32) begin
          n_fails++; $display("FAIL ur_ones frame=%0d got=%0d exp=32", k, ones_in_frame(k));
        end
      end
    end
  endtask

  task automatic test_stop();
    int n_tick = 0;
    int wait_cnt = 0;
    bit stopping = 0;
    bit done = 0;
    reset_dut();
    in_valid = 1;
    for (int i = 0; i < 3*OSR + 20; i++) begin
      in_data = 16'($urandom_range(0, 40000) - 20000);
      if (!stopping && n_tick == 2 && m_phase == 10) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fails++; $display("FAIL stop_pending got=%b exp=0", in_ready); end
        stop = 1; in_valid = 0; stopping = 1;
      end
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL stop_cycle cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
      end
      if (sample_tick) n_tick++;
      if (stopping && !done) begin
        if (m_run) begin
          wait_cnt++;
          n_checks++;
          if (busy !== 1'b1) begin n_fails++; $display("FAIL stop_wait got=%b exp=1", busy); end
        end else begin
          n_checks++;
          if ({busy, dsm_out, in_ready} !== 3'b001) begin
            n_fails++; $display("FAIL stop_idle busy_out_rdy=%b exp=001", {busy, dsm_out, in_ready});
          end
          stop = 0; done = 1;
        end
      end
    end
    n_checks++;
    if (!done || wait_cnt !== OSR - 11) begin
      n_fails++; $display("FAIL stop_latency done=%0d wait=%0d exp=%0d", done, wait_cnt, OSR - 11);
    end
    stop = 0;
  endtask

  task automatic test_reset_mid();
    int n_tick = 0;
    bit hit = 0;
    reset_dut();
    in_valid = 1;
    for (int i = 0; i < 4*OSR && !hit; i++) begin
      in_data = 16'($urandom_range(0, 40000) - 20000);
      if (n_tick == 2 && m_phase == 30) begin
        rst = 1; in_valid = 0;
        step();
        rst = 0;
        hit = 1;
        n_checks++;
        if (obs !== 5'b01000) begin n_fails++; $display("FAIL rst_mid obs=%b exp=01000", obs); end
      end else begin
        step();
        if (sample_tick) n_tick++;
      end
    end
    n_checks++;
    if (!hit) begin n_fails++; $display("FAIL rst_mid_reach got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (obs !== 5'b01000) begin n_fails++; $display("FAIL rst_mid_idle obs=%b exp=01000", obs); end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 4000; i++) begin
      in_valid    = ($urandom_range(0, 1) == 1);
      in_data     = 16'($urandom_range(0, 49152) - 24576);
      stop        = ($urandom_range(0, 299) == 0);
      clear_flags = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL rand_cycle cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
      end
    end
    rst = 0; in_valid = 0; stop = 0; clear_flags = 0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dc(16384, 46, 50);
    test_dc(-16384, 14, 18);
    test_back_to_back();
    test_underrun();
    test_stop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
